// File: rtl/slow_cfg_pkg.sv
// Shared types and reset defaults for the slow-access settings register.
// The field helper extracts the timeout field above the enable bits.
package slow_cfg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam int NCH_DEF = 7;
  localparam int TW_DEF  = 4;

  // Bit 6..0: IACK, VIA, IWM, SCC, SCSI, Snd, ClockGate
  localparam logic [NCH_DEF-1:0] DEF_EN = 7'b1110110;
  localparam logic [TW_DEF-1:0]  DEF_TO = 4'h3;

  function automatic logic [31:0] field_hi(input logic [31:0] addr, input int unsigned nch);
    return addr >> nch;
  endfunction

endpackage

// File: rtl/slow_cfg_bus_strobe.sv
// Registered strobe sample with a one-cycle registered rising-edge pulse.
// cap_o marks the edge at which the strobe is first seen high (address capture).
module bus_strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strb_i,
  output logic pulse_o,
  output logic cap_o
);

  logic r_q;
  logic rd_q;
  logic p_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q  <= 1'b0;
      rd_q <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      r_q  <= strb_i;
      rd_q <= r_q;
      p_q  <= r_q & ~rd_q;
    end
  end

  assign cap_o   = strb_i & ~r_q;
  assign pulse_o = p_q;

endmodule

// File: rtl/slow_cfg.sv
// Slow-access settings register: one update per bus write, with optional
// confirm window that reverts to the last confirmed setting on expiry.
//
// state | meaning
// IDLE  | active setting is confirmed (or confirm disabled)
// PEND  | new setting in effect, waiting for confirm before timer expires
module slow_cfg #(
  parameter int              NCH         = 7,
  parameter int              TW          = 4,
  parameter logic [NCH-1:0]  DEF_EN      = slow_cfg_pkg::DEF_EN,
  parameter logic [TW-1:0]   DEF_TO      = slow_cfg_pkg::DEF_TO,
  parameter bit              CONFIRM_EN  = 1'b1,
  parameter int              CONFIRM_CYC = 8
) (
  input  logic              CLK,
  input  logic              POR,
  input  logic              BACT,
  input  logic [TW+NCH-1:0] A,
  input  logic              SetCSWR,
  input  logic              SetCSCF,
  output logic [NCH-1:0]    SlowEn,
  output logic [TW-1:0]     SlowTimeout,
  output logic              Pending,
  output logic              Reverted
);

  import slow_cfg_pkg::*;

  localparam int TMR_W = (CONFIRM_CYC > 2) ? $clog2(CONFIRM_CYC) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(CONFIRM_CYC - 1);
  localparam logic [TW+NCH-1:0] DEF_SET  = {DEF_TO, DEF_EN};

  logic wr_p;
  logic wr_cap;
  logic cf_p;
  logic cf_cap_unused;

  bus_strobe_edge u_wr (
    .clk_i  (CLK),
    .rst_i  (POR),
    .strb_i (BACT & SetCSWR),
    .pulse_o(wr_p),
    .cap_o  (wr_cap)
  );

  bus_strobe_edge u_cf (
    .clk_i  (CLK),
    .rst_i  (POR),
    .strb_i (BACT & SetCSCF),
    .pulse_o(cf_p),
    .cap_o  (cf_cap_unused)
  );

  state_e              state_q;
  logic [TW+NCH-1:0]   areg_q;
  logic [TW+NCH-1:0]   active_q;
  logic [TW+NCH-1:0]   good_q;
  logic [TMR_W-1:0]    timer_q;
  logic                pend_q;
  logic                rev_q;

  always_ff @(posedge CLK) begin
    if (POR) begin
      state_q  <= IDLE;
      areg_q   <= DEF_SET;
      active_q <= DEF_SET;
      good_q   <= DEF_SET;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      if (wr_cap) begin
        areg_q <= A;
      end
      case (state_q)
        IDLE: begin
          if (wr_p) begin
            if (CONFIRM_EN) begin
              good_q   <= active_q;
              active_q <= areg_q;
              timer_q  <= TMR_LOAD;
              rev_q    <= 1'b0;
              pend_q   <= 1'b1;
              state_q  <= PEND;
            end else begin
              active_q <= areg_q;
              good_q   <= areg_q;
            end
          end
        end
        PEND: begin
          // Write beats confirm beats timeout within one cycle.
          if (wr_p) begin
            active_q <= areg_q;
            timer_q  <= TMR_LOAD;
          end else if (cf_p) begin
            good_q  <= active_q;
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timer_q == '0) begin
            active_q <= good_q;
            rev_q    <= 1'b1;
            pend_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SlowEn      = active_q[NCH-1:0];
  assign SlowTimeout = TW'(field_hi(32'(active_q), NCH));
  assign Pending     = pend_q;
  assign Reverted    = rev_q;

endmodule

// File: tb/tb_slow_cfg.sv
// Randomized and directed bench for slow_cfg, with a deadline-based reference
// model covering both the confirm-enabled and immediate-commit builds.
module tb_slow_cfg;

  logic        clk;
  logic        por;
  logic        bact;
  logic        cswr;
  logic        cscf;
  logic [10:0] a;

  logic [6:0]  en_n, en_c;
  logic [3:0]  to_n, to_c;
  logic        pend_n, pend_c, rev_n, rev_c;

  int n_chk;
  int n_pass;
  int edge_no;

  localparam logic [10:0] DEFV = {4'h3, 7'h76};
  localparam int          WIN  = 8;

  // reference model state, index 0 = immediate commit, 1 = confirm mode
  logic [10:0] m_act [2];
  logic [10:0] m_good[2];
  logic        m_pend[2];
  logic        m_rev [2];
  int          m_dl  [2];
  logic        s1, s2, s3, c1, c2, c3;
  logic [10:0] a1, a2;

  slow_cfg #(.CONFIRM_EN(1'b0), .CONFIRM_CYC(WIN)) dut_n (
    .CLK(clk), .POR(por), .BACT(bact), .A(a), .SetCSWR(cswr), .SetCSCF(cscf),
    .SlowEn(en_n), .SlowTimeout(to_n), .Pending(pend_n), .Reverted(rev_n)
  );

  slow_cfg #(.CONFIRM_EN(1'b1), .CONFIRM_CYC(WIN)) dut_c (
    .CLK(clk), .POR(por), .BACT(bact), .A(a), .SetCSWR(cswr), .SetCSCF(cscf),
    .SlowEn(en_c), .SlowTimeout(to_c), .Pending(pend_c), .Reverted(rev_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
  endtask

  // A write (or confirm) takes effect two edges after its strobe is first
  // sampled high following a low sample; pending settings expire WIN edges
  // after they took effect.
  task automatic model_step();
    logic       s_now, c_now, wr, cf;
    logic [10:0] a_now;
    s_now = bact & cswr;
    c_now = bact & cscf;
    a_now = a;
    edge_no++;
    if (por) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = DEFV; m_good[k] = DEFV; m_pend[k] = 1'b0; m_rev[k] = 1'b0; m_dl[k] = 0;
      end
      s1 = 0; s2 = 0; s3 = 0; c1 = 0; c2 = 0; c3 = 0;
    end else begin
      wr = s2 & ~s3;
      cf = c2 & ~c3;
      if (wr) begin
        m_act[0] = a2;
        m_good[0] = a2;
      end
      if (!m_pend[1]) begin
        if (wr) begin
          m_good[1] = m_act[1];
          m_act[1]  = a2;
          m_pend[1] = 1'b1;
          m_rev[1]  = 1'b0;
          m_dl[1]   = edge_no + WIN;
        end
      end else if (wr) begin
        m_act[1] = a2;
        m_dl[1]  = edge_no + WIN;
      end else if (cf) begin
        m_good[1] = m_act[1];
        m_pend[1] = 1'b0;
      end else if (edge_no == m_dl[1]) begin
        m_act[1]  = m_good[1];
        m_rev[1]  = 1'b1;
        m_pend[1] = 1'b0;
      end
      s3 = s2; s2 = s1; s1 = s_now;
      c3 = c2; c2 = c1; c1 = c_now;
      a2 = a1; a1 = a_now;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("en_n",   32'(en_n),   32'(m_act[0][6:0]));
    chk("to_n",   32'(to_n),   32'(m_act[0][10:7]));
    chk("pend_n", 32'(pend_n), 32'(m_pend[0]));
    chk("rev_n",  32'(rev_n),  32'(m_rev[0]));
    chk("en_c",   32'(en_c),   32'(m_act[1][6:0]));
    chk("to_c",   32'(to_c),   32'(m_act[1][10:7]));
    chk("pend_c", 32'(pend_c), 32'(m_pend[1]));
    chk("rev_c",  32'(rev_c),  32'(m_rev[1]));
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic c, input logic [10:0] addr);
    bact = w | c; cswr = w; cscf = c; a = addr;
  endtask

  task automatic release_bus();
    bact = 1'b0; cswr = 1'b0; cscf = 1'b0; a = 11'($urandom);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_reset(input int k);
    por = 1'b1;
    idle(k);
    por = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; edge_no = 0;
    por = 1'b1; bact = 1'b0; cswr = 1'b0; cscf = 1'b0; a = '0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = DEFV; m_good[k] = DEFV; m_pend[k] = 1'b0; m_rev[k] = 1'b0; m_dl[k] = 0;
    end
    s1 = 0; s2 = 0; s3 = 0; c1 = 0; c2 = 0; c3 = 0; a1 = '0; a2 = '0;
    @(negedge clk);

    // reset values
    do_reset(2);
    chk("rst_en",   32'(en_c),   32'h76);
    chk("rst_to",   32'(to_c),   32'h3);
    chk("rst_pend", 32'(pend_c), 32'h0);
    chk("rst_rev",  32'(rev_c),  32'h0);

    // write, then confirm four cycles later
    drive(1, 0, 11'h5A3); tick(); release_bus(); idle(2);
    chk("wr_to_n",   32'(to_n),   32'hB);
    chk("wr_en_n",   32'(en_n),   32'h23);
    chk("wr_pend_n", 32'(pend_n), 32'h0);
    chk("wr_pend_c", 32'(pend_c), 32'h1);
    chk("wr_en_c",   32'(en_c),   32'h23);
    idle(1);
    drive(0, 1, 11'h000); tick(); release_bus();
    idle(1);
    chk("cf_pend_hold", 32'(pend_c), 32'h1);
    idle(1);
    chk("cf_pend_fall", 32'(pend_c), 32'h0);
    chk("cf_en",        32'(en_c),   32'h23);
    chk("cf_to",        32'(to_c),   32'hB);
    chk("cf_rev",       32'(rev_c),  32'h0);

    // unconfirmed write reverts after the window
    do_reset(2);
    drive(1, 0, 11'h5A3); tick(); release_bus(); idle(2);
    chk("to_pend0", 32'(pend_c), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_pend_win", 32'(pend_c), 32'h1);
    end
    tick();
    chk("to_pend_end", 32'(pend_c), 32'h0);
    chk("to_rev",      32'(rev_c),  32'h1);
    chk("to_en",       32'(en_c),   32'h76);
    chk("to_to",       32'(to_c),   32'h3);
    drive(1, 0, 11'h012); tick(); release_bus(); idle(2);
    chk("rev_clr", 32'(rev_c), 32'h0);
    chk("rev_en",  32'(en_c),  32'h12);

    // long strobe gives one update
    do_reset(2);
    drive(1, 0, 11'h5A3); idle(3);
    chk("hold_en", 32'(en_c), 32'h23);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("hold_en_win", 32'(en_c), 32'h23);
    end
    release_bus();
    tick();
    chk("hold_rev", 32'(rev_c), 32'h1);
    chk("hold_en_n", 32'(en_n), 32'h23);

    // second write in window reloads timer; revert target is pre-window value
    drive(1, 0, 11'h5A3); tick(); release_bus(); idle(3);
    drive(1, 0, 11'h012); tick(); release_bus(); idle(2);
    chk("rl_en",   32'(en_c),   32'h12);
    chk("rl_pend", 32'(pend_c), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("rl_pend_win", 32'(pend_c), 32'h1);
    end
    tick();
    chk("rl_rev", 32'(rev_c), 32'h1);
    chk("rl_en_back", 32'(en_c), 32'h76);
    chk("rl_to_back", 32'(to_c), 32'h3);

    // simultaneous write and confirm: write wins; then reset mid-window
    do_reset(2);
    drive(1, 0, 11'h5A3); tick(); release_bus(); idle(3);
    drive(1, 1, 11'h012); tick(); release_bus(); idle(2);
    chk("wc_pend", 32'(pend_c), 32'h1);
    chk("wc_en",   32'(en_c),   32'h12);
    chk("wc_to",   32'(to_c),   32'h0);
    idle(2);
    do_reset(1);
    chk("mid_en",   32'(en_c),   32'h76);
    chk("mid_to",   32'(to_c),   32'h3);
    chk("mid_pend", 32'(pend_c), 32'h0);
    chk("mid_rev",  32'(rev_c),  32'h0);
    idle(4);
    chk("mid_idle", 32'(pend_c), 32'h0);

    // random traffic
    for (int i = 0; i < 1200; i++) begin
      por  = ($urandom_range(0, 149) == 0);
      bact = ($urandom_range(0, 3) != 0);
      cswr = ($urandom_range(0, 3) == 0);
      cscf = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) a = 11'($urandom);
      tick();
    end
    por = 1'b0;
    release_bus();
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
